dlx_mc_ctrl: RTL and testbench

Parametrised multi-cycle sequencer for the DLX core; successor to the fixed 5-state IF/ID/EX/MEM/WB ring.
- Drives one-hot stage enables to the datapath.
- Adds ready handshakes, variable-latency EX, MEM/WB skipping, global stall, HALT, a wait watchdog and a retired-instruction counter.
- Sits between the decoder/memory interfaces and the datapath stage registers.

---
 rtl/dlx_pkg.sv | 30 +++
 rtl/dlx_wdog.sv | 30 +++
 rtl/dlx_mc_ctrl.sv | 131 +++++++++++++
 tb/tb_dlx_mc_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX multi-cycle control path.
// Stage-enable vectors are ordered {IF,ID,EX,MEM,WB} with IF in the MSB.
package dlx_pkg;

    typedef enum logic [2:0] {sIF, sID, sEX, sMEM, sWB, sHALT, sERR} ctrl_state_t;

    localparam int NUM_STATES = 7;
    localparam int EN_W       = 5;
    localparam int EN_IF      = 4;
    localparam int EN_ID      = 3;
    localparam int EN_EX      = 2;
    localparam int EN_MEM     = 1;
    localparam int EN_WB      = 0;

    // HALT and ERR map to an all-zero vector, so the datapath stays frozen there.
    function automatic logic [EN_W-1:0] stage_onehot(input ctrl_state_t s);
        logic [EN_W-1:0] v;
        v = '0;
        case (s)
            sIF:     v[EN_IF]  = 1'b1;
            sID:     v[EN_ID]  = 1'b1;
            sEX:     v[EN_EX]  = 1'b1;
            sMEM:    v[EN_MEM] = 1'b1;
            sWB:     v[EN_WB]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dlx_wdog.sv
// Wait watchdog: counts consecutive enabled cycles with ready low and
// flags expiry on the cycle that would make it TIMEOUT in a row.
module dlx_wdog #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic ready,
    input  logic clr,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TO_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wait_cnt <= '0;
        end else if (en && !ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A ready arriving in the final cycle suppresses expiry.
    assign expire = (TIMEOUT > 0) && en && !ready && (wait_cnt == LAST);

endmodule

// File: rtl/dlx_mc_ctrl.sv
// Multi-cycle DLX sequencer: one-hot stage enables with ready handshakes,
// MEM/WB skipping, global stall, HALT, wait watchdog and retire counter.
module dlx_mc_ctrl
    import dlx_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4,
    parameter int ICNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              if_ready,
    input  logic              ex_done,
    input  logic              mem_ready,
    input  logic              halt,
    input  logic              skip_mem,
    input  logic              skip_wb,
    output logic              IF,
    output logic              ID,
    output logic              EX,
    output logic              MEM,
    output logic              WB,
    output logic              instr_done,
    output logic [ICNT_W-1:0] retired_cnt,
    output logic              halted,
    output logic              timeout_err
);

    ctrl_state_t     state;
    ctrl_state_t     state_nx;
    logic            skip_mem_q;
    logic            skip_wb_q;
    logic            wait_state;
    logic            wait_ready;
    logic            expire;
    logic            done_nx;
    logic [EN_W-1:0] stage_en;

    always_comb begin
        wait_state = 1'b1;
        wait_ready = 1'b1;
        case (state)
            sIF:     wait_ready = if_ready;
            sEX:     wait_ready = ex_done;
            sMEM:    wait_ready = mem_ready;
            default: wait_state = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        if (!stall) begin
            case (state)
                sIF: if (if_ready) state_nx = sID;
                sID: begin
                    if (halt) begin
                        state_nx = sHALT;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = sEX;
                    end
                end
                sEX: begin
                    if (ex_done) begin
                        if (!skip_mem_q) begin
                            state_nx = sMEM;
                        end else if (!skip_wb_q) begin
                            state_nx = sWB;
                        end else begin
                            state_nx = sIF;
                            done_nx  = 1'b1;
                        end
                    end
                end
                sMEM: begin
                    if (mem_ready) begin
                        if (skip_wb_q) begin
                            state_nx = sIF;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = sWB;
                        end
                    end
                end
                sWB: begin
                    state_nx = sIF;
                    done_nx  = 1'b1;
                end
                default: state_nx = state;
            endcase
            if (expire) state_nx = sERR;
        end
    end

    dlx_wdog #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .en    (wait_state && !stall),
        .ready (wait_ready),
        .clr   (state_nx != state),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= sIF;
            skip_mem_q  <= 1'b0;
            skip_wb_q   <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state <= state_nx;
            if (!stall && state == sID) begin
                skip_mem_q <= skip_mem;
                skip_wb_q  <= skip_wb;
            end
            if (done_nx) retired_cnt <= retired_cnt + 1'b1;
        end
    end

    assign stage_en                = stall ? '0 : stage_onehot(state);
    assign {IF, ID, EX, MEM, WB}   = stage_en;
    assign instr_done              = done_nx && !reset;
    assign halted                  = (state == sHALT);
    assign timeout_err             = (state == sERR);

endmodule

// File: tb/tb_dlx_mc_ctrl.sv
// Directed self-checking bench for dlx_mc_ctrl with TIMEOUT=15 and a
// 4-bit retire counter so wraparound is reachable.
module tb_dlx_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall, if_ready, ex_done, mem_ready, halt, skip_mem, skip_wb;
    logic       IF, ID, EX, MEM, WB;
    logic       instr_done, halted, timeout_err;
    logic [3:0] retired_cnt;
    logic [4:0] en;

    int checks = 0;
    int passed = 0;

    localparam logic [4:0] E_IF = 5'b10000, E_ID = 5'b01000, E_EX = 5'b00100;
    localparam logic [4:0] E_MEM = 5'b00010, E_WB = 5'b00001, E_NONE = 5'b00000;

    dlx_mc_ctrl #(
        .TIMEOUT(15),
        .TO_W   (4),
        .ICNT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .if_ready   (if_ready),
        .ex_done    (ex_done),
        .mem_ready  (mem_ready),
        .halt       (halt),
        .skip_mem   (skip_mem),
        .skip_wb    (skip_wb),
        .IF         (IF),
        .ID         (ID),
        .EX         (EX),
        .MEM        (MEM),
        .WB         (WB),
        .instr_done (instr_done),
        .retired_cnt(retired_cnt),
        .halted     (halted),
        .timeout_err(timeout_err)
    );

    assign en = {IF, ID, EX, MEM, WB};

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic st, input logic ifr,
                                 input logic exd, input logic memr, input logic hlt,
                                 input logic smem, input logic swb);
        reset     = r;
        stall     = st;
        if_ready  = ifr;
        ex_done   = exd;
        mem_ready = memr;
        halt      = hlt;
        skip_mem  = smem;
        skip_wb   = swb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset and zero-wait full path
        applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("rst_en", en, E_IF);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_retired", retired_cnt, 0);
        checkOutput("rst_done", instr_done, 0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("ring_en", en, E_IF >> (i % 5));
            checkOutput("ring_done", instr_done, (i % 5) == 4);
            tick();
        end
        checkOutput("ring_retired", retired_cnt, 4);

        // skip_mem only: IF, ID, EX, WB
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 1, 0);
        checkOutput("skm_id", en, E_ID);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("skm_ex", en, E_EX);
        checkOutput("skm_ex_done", instr_done, 0);
        tick();
        checkOutput("skm_wb", en, E_WB);
        checkOutput("skm_wb_done", instr_done, 1);
        tick();
        checkOutput("skm_retired", retired_cnt, 5);
        checkOutput("skm_if", en, E_IF);

        // both skips: IF, ID, EX
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 1, 1);
        checkOutput("skb_id", en, E_ID);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("skb_ex", en, E_EX);
        checkOutput("skb_ex_done", instr_done, 1);
        tick();
        checkOutput("skb_if", en, E_IF);
        checkOutput("skb_retired", retired_cnt, 6);

        // MEM wait with a stall in the middle
        tick();
        tick();
        checkOutput("mw_ex", en, E_EX);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("mw_mem1", en, E_MEM);
        tick();
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("mw_stall_en", en, E_NONE);
        checkOutput("mw_stall_done", instr_done, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("mw_mem2", en, E_MEM);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("mw_mem3", en, E_MEM);
        checkOutput("mw_mem3_done", instr_done, 0);
        tick();
        checkOutput("mw_wb", en, E_WB);
        checkOutput("mw_wb_done", instr_done, 1);
        tick();
        checkOutput("mw_if", en, E_IF);
        checkOutput("mw_retired", retired_cnt, 7);
        checkOutput("mw_timeout", timeout_err, 0);

        // IF starved for 15 non-stalled cycles (one stall interleaved)
        for (int n = 1; n <= 15; n++) begin
            applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
            checkOutput("to_wait_en", en, E_IF);
            tick();
            if (n == 7) begin
                applyStimulus(0, 1, 0, 1, 1, 0, 0, 0);
                tick();
                checkOutput("to_after_stall", timeout_err, 0);
            end
        end
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_err_en", en, E_NONE);
        tick();
        tick();
        tick();
        checkOutput("to_err_sticky", timeout_err, 1);
        checkOutput("to_err_sticky_en", en, E_NONE);

        applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("to_rst_en", en, E_IF);
        checkOutput("to_rst_err", timeout_err, 0);
        checkOutput("to_rst_retired", retired_cnt, 0);

        // ready arrives on the 15th cycle: no error
        for (int n = 1; n <= 14; n++) begin
            applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("late_if", en, E_IF);
        tick();
        checkOutput("late_id", en, E_ID);
        checkOutput("late_err", timeout_err, 0);

        // HALT in ID
        applyStimulus(0, 0, 1, 1, 1, 1, 0, 0);
        checkOutput("halt_done", instr_done, 1);
        tick();
        checkOutput("halt_flag", halted, 1);
        checkOutput("halt_retired", retired_cnt, 1);
        for (int n = 0; n < 10; n++) begin
            checkOutput("halt_en", en, E_NONE);
            tick();
        end
        checkOutput("halt_sticky", halted, 1);
        applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("halt_rst_en", en, E_IF);
        checkOutput("halt_rst_flag", halted, 0);
        checkOutput("halt_rst_retired", retired_cnt, 0);

        // 17 zero-wait instructions wrap the 4-bit counter
        for (int c = 1; c <= 85; c++) begin
            tick();
            if (c == 75) checkOutput("wrap_15", retired_cnt, 15);
            if (c == 80) checkOutput("wrap_0", retired_cnt, 0);
            if (c == 85) checkOutput("wrap_1", retired_cnt, 1);
        end

        // reset while waiting in EX
        tick();
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
        tick();
        checkOutput("exrst_ex", en, E_EX);
        checkOutput("exrst_done", instr_done, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
        checkOutput("exrst_if", en, E_IF);
        checkOutput("exrst_retired", retired_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
